// File: rtl/usb_pkg.sv
// Shared types and constants for the USB-style packet serializer.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S_PID,
    S_ADDR,
    S_ENDP,
    S_CRC5,
    S_DATA,
    S_CRC16
  } state_t;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int unsigned PID_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 7;
  localparam int unsigned ENDP_BITS  = 4;
  localparam int unsigned CRC5_BITS  = 5;
  localparam int unsigned CRC16_BITS = 16;

  // True for the PIDs this serializer knows how to send.
  function automatic logic pid_known(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_DATA0) ||
           (p == PID_ACK) || (p == PID_NAK);
  endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC LFSR: one message bit per enabled cycle, MSB-side feedback.
module usb_crc_serial #(
  parameter int unsigned   W    = 5,
  parameter logic [W-1:0]  POLY = '0,
  parameter logic [W-1:0]  INIT = '1
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] crc
);

  logic [W-1:0] crc_q, crc_d;
  logic         fb;

  // Next remainder: clear to INIT, or shift in one bit with polynomial feedback.
  always_comb begin
    fb    = crc_q[W-1] ^ din;
    crc_d = crc_q;
    if (clr) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_pkt_serializer.sv
// Packet serializer: captures PID/token/payload by handshake and shifts the
// packet out LSB first, one bit per unpaused cycle, appending CRC5 or CRC16.
module usb_pkt_serializer
  import usb_pkg::*;
#(
  parameter  int unsigned DATA_BYTES = 8,
  localparam int unsigned LEN_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    pktready,
  input  logic [3:0]              pid,
  input  logic [6:0]              addr,
  input  logic [3:0]              endp,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [LEN_W-1:0]        len,
  input  logic                    pause,
  output logic                    outb,
  output logic                    sending,
  output logic                    gotpkt,
  output logic                    pktdone,
  output logic                    pkterr
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned CNT_W  = (LEN_W + 3 > 5) ? LEN_W + 3 : 5;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          pid_q, pid_d;
  logic [6:0]          addr_q, addr_d;
  logic [3:0]          endp_q, endp_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic                crc5_clr, crc5_en;
  logic                crc16_clr, crc16_en;
  logic [CRC5_BITS-1:0]  crc5;
  logic [CRC16_BITS-1:0] crc16;

  logic                pkt_valid;
  logic                field_last;
  state_t              nxt;
  logic [7:0]          pid_byte;
  logic [2:0]          crc5_idx;
  logic [CNT_W-1:0]    data_bits_m1;

  // Next-state, field sequencing and serial output; field_last/nxt describe
  // the current field so the counter and state step in one shared place.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pid_d        = pid_q;
    addr_d       = addr_q;
    endp_d       = endp_q;
    data_d       = data_q;
    len_d        = len_q;
    outb         = 1'b0;
    sending      = 1'b0;
    gotpkt       = 1'b0;
    pktdone      = 1'b0;
    pkterr       = 1'b0;
    crc5_clr     = 1'b0;
    crc5_en      = 1'b0;
    crc16_clr    = 1'b0;
    crc16_en     = 1'b0;
    field_last   = 1'b0;
    nxt          = IDLE;
    pid_byte     = {~pid_q, pid_q};
    crc5_idx     = 3'd4 - cnt_q[2:0];
    data_bits_m1 = CNT_W'({len_q, 3'b000}) - CNT_W'(1);
    pkt_valid    = pid_known(pid) && (len <= LEN_W'(DATA_BYTES));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pktready) state_d = LOAD;
      end
      LOAD: begin
        gotpkt    = 1'b1;
        pid_d     = pid;
        addr_d    = addr;
        endp_d    = endp;
        data_d    = data;
        len_d     = len;
        crc5_clr  = 1'b1;
        crc16_clr = 1'b1;
        cnt_d     = '0;
        if (pkt_valid) begin
          state_d = S_PID;
        end else begin
          pkterr  = 1'b1;
          state_d = IDLE;
        end
      end
      S_PID: begin
        sending    = 1'b1;
        outb       = pid_byte[cnt_q[2:0]];
        field_last = (cnt_q[2:0] == 3'd7);
        if ((pid_q == PID_OUT) || (pid_q == PID_IN)) nxt = S_ADDR;
        else if (pid_q == PID_DATA0)                 nxt = (len_q == '0) ? S_CRC16 : S_DATA;
        else                                         nxt = IDLE;
      end
      S_ADDR: begin
        sending    = 1'b1;
        outb       = addr_q[cnt_q[2:0]];
        crc5_en    = !pause;
        field_last = (cnt_q[2:0] == 3'd6);
        nxt        = S_ENDP;
      end
      S_ENDP: begin
        sending    = 1'b1;
        outb       = endp_q[cnt_q[1:0]];
        crc5_en    = !pause;
        field_last = (cnt_q[1:0] == 2'd3);
        nxt        = S_CRC5;
      end
      S_CRC5: begin
        sending    = 1'b1;
        outb       = ~crc5[crc5_idx];
        field_last = (cnt_q[2:0] == 3'd4);
        nxt        = IDLE;
      end
      S_DATA: begin
        sending    = 1'b1;
        outb       = data_q[0];
        crc16_en   = !pause;
        if (!pause) data_d = data_q >> 1;
        field_last = (cnt_q == data_bits_m1);
        nxt        = S_CRC16;
      end
      S_CRC16: begin
        sending    = 1'b1;
        outb       = ~crc16[~cnt_q[3:0]];
        field_last = (cnt_q[3:0] == 4'hF);
        nxt        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared bit/field advance for all shifting states; pause freezes everything.
    if (sending && !pause) begin
      if (field_last) begin
        cnt_d   = '0;
        state_d = nxt;
        pktdone = (nxt == IDLE);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, bit counter and captured packet fields.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pid_q   <= '0;
      addr_q  <= '0;
      endp_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  usb_crc_serial #(.W(CRC5_BITS), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (crc5_clr),
    .en    (crc5_en),
    .din   (outb),
    .crc   (crc5)
  );

  usb_crc_serial #(.W(CRC16_BITS), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (crc16_clr),
    .en    (crc16_en),
    .din   (outb),
    .crc   (crc16)
  );

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Self-checking bench for usb_pkt_serializer: expected bit streams come from a
// packet-level model with CRCs computed by polynomial long division.
module tb_usb_pkt_serializer;

  localparam int DB = 8;
  localparam int LW = $clog2(DB + 1);

  logic            clk = 1'b0;
  logic            rst_L;
  logic            pktready;
  logic [3:0]      pid;
  logic [6:0]      addr;
  logic [3:0]      endp;
  logic [8*DB-1:0] data;
  logic [LW-1:0]   len;
  logic            pause;
  logic            outb, sending, gotpkt, pktdone, pkterr;

  int errors = 0;
  int checks = 0;
  bit exp_bits[$];

  usb_pkt_serializer #(.DATA_BYTES(DB)) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .pktready (pktready),
    .pid      (pid),
    .addr     (addr),
    .endp     (endp),
    .data     (data),
    .len      (len),
    .pause    (pause),
    .outb     (outb),
    .sending  (sending),
    .gotpkt   (gotpkt),
    .pktdone  (pktdone),
    .pkterr   (pkterr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Remainder of (M(x)*x^w + INIT(x)*x^n) mod G(x); first-sent bit is highest degree.
  function automatic logic [15:0] crc_div(input logic [127:0] m, input int n, input int w,
                                          input logic [16:0] gen, input logic [15:0] init);
    logic [127:0] dv;
    dv = (m << w) ^ (128'(init) << n);
    for (int k = n + w - 1; k >= w; k--)
      if (dv[k]) dv = dv ^ (128'(gen) << (k - w));
    return dv[15:0];
  endfunction

  task automatic build_expected(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                                input logic [8*DB-1:0] d, input logic [LW-1:0] l);
    logic [7:0]   pb;
    logic [127:0] m;
    logic [15:0]  r;
    logic [4:0]   f5;
    logic [15:0]  f16;
    int           n;
    exp_bits.delete();
    pb = {~p, p};
    for (int i = 0; i < 8; i++) exp_bits.push_back(pb[i]);
    m = '0;
    n = 0;
    if (p == 4'b0001 || p == 4'b1001) begin
      for (int i = 0; i < 7; i++) begin exp_bits.push_back(a[i]); m = {m[126:0], a[i]}; n++; end
      for (int i = 0; i < 4; i++) begin exp_bits.push_back(e[i]); m = {m[126:0], e[i]}; n++; end
      r  = crc_div(m, n, 5, 17'h00025, 16'h001F);
      f5 = ~r[4:0];
      for (int i = 4; i >= 0; i--) exp_bits.push_back(f5[i]);
    end else if (p == 4'b0011) begin
      for (int i = 0; i < 8 * int'(l); i++) begin
        exp_bits.push_back(d[i]);
        m = {m[126:0], d[i]};
        n++;
      end
      r   = crc_div(m, n, 16, 17'h18005, 16'hFFFF);
      f16 = ~r;
      for (int i = 15; i >= 0; i--) exp_bits.push_back(f16[i]);
    end
  endtask

  task automatic run_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                         input logic [8*DB-1:0] d, input logic [LW-1:0] l,
                         input bit pz, input bit expect_err);
    int i;
    int cyc;
    int nbits;
    if (!expect_err) build_expected(p, a, e, d, l);
    nbits = exp_bits.size();
    @(negedge clk);
    pid = p; addr = a; endp = e; data = d; len = l; pktready = 1'b1; pause = 1'b0;
    #1;
    chk("idle_gotpkt", gotpkt, 0);
    chk("idle_sending", sending, 0);
    @(negedge clk);
    pktready = 1'b0;
    #1;
    chk("load_gotpkt", gotpkt, 1);
    chk("load_pkterr", pkterr, expect_err);
    chk("load_sending", sending, 0);
    if (expect_err) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        pktready = (k == 0) ? 1'b0 : 1'b0;
        #1;
        chk("rej_sending", sending, 0);
        chk("rej_pkterr", pkterr, 0);
        chk("rej_outb", outb, 0);
      end
      return;
    end
    i = 0;
    cyc = 0;
    while (i < nbits && cyc < 4000) begin
      @(negedge clk);
      pause    = pz ? ($urandom_range(0, 2) == 0) : 1'b0;
      pktready = 1'($urandom);
      pid      = 4'($urandom);
      addr     = 7'($urandom);
      data     = {$urandom, $urandom};
      #1;
      chk("sending", sending, 1);
      chk("outb", outb, exp_bits[i]);
      chk("pktdone", pktdone, (i == nbits - 1) && !pause);
      chk("gotpkt_busy", gotpkt, 0);
      if (!pause) i++;
      cyc++;
    end
    if (cyc >= 4000) chk("bit_budget", i, nbits);
    @(negedge clk);
    pause = 1'b0;
    pktready = 1'b0;
    #1;
    chk("post_sending", sending, 0);
    chk("post_outb", outb, 0);
    chk("post_pktdone", pktdone, 0);
  endtask

  initial begin
    logic [3:0]      pids [5];
    logic [8*DB-1:0] rd;
    logic [3:0]      rp;
    pids = '{4'b0001, 4'b1001, 4'b0011, 4'b0010, 4'b1010};
    rst_L = 1'b0; pktready = 1'b0; pid = '0; addr = '0; endp = '0;
    data = '0; len = '0; pause = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_outb", outb, 0);
    chk("rst_sending", sending, 0);
    chk("rst_gotpkt", gotpkt, 0);
    chk("rst_pktdone", pktdone, 0);
    chk("rst_pkterr", pkterr, 0);
    @(negedge clk);
    rst_L = 1'b1;

    run_pkt(4'b0010, 7'd0, 4'd0, '0, '0, 1'b0, 1'b0);                 // ACK
    run_pkt(4'b1010, 7'($urandom), 4'($urandom), '0, '0, 1'b0, 1'b0); // NAK
    run_pkt(4'b0001, 7'd0, 4'd0, '0, '0, 1'b0, 1'b0);                 // OUT addr0 endp0
    run_pkt(4'b1001, 7'($urandom), 4'($urandom), '0, '0, 1'b0, 1'b0); // IN random token
    run_pkt(4'b0011, '0, '0, '0, LW'(0), 1'b0, 1'b0);                 // DATA0 empty
    run_pkt(4'b0011, '0, '0, {$urandom, $urandom}, LW'(DB), 1'b0, 1'b0);

    rd = {$urandom, $urandom};
    run_pkt(4'b0011, '0, '0, rd, LW'(3), 1'b0, 1'b0);
    run_pkt(4'b0011, '0, '0, rd, LW'(3), 1'b1, 1'b0);
    run_pkt(4'b0001, 7'($urandom), 4'($urandom), '0, '0, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rp = pids[$urandom_range(0, 4)];
      run_pkt(rp, 7'($urandom), 4'($urandom), {$urandom, $urandom},
              LW'($urandom_range(0, DB)), 1'($urandom), 1'b0);
    end

    run_pkt(4'b0110, 7'd5, 4'd1, '0, '0, 1'b0, 1'b1);                 // unknown pid
    run_pkt(4'b0011, 7'd0, 4'd0, '1, LW'(DB + 1), 1'b0, 1'b1);        // over-length payload
    run_pkt(4'b0010, 7'd0, 4'd0, '0, '0, 1'b0, 1'b0);                 // recovers after reject

    // Abort a DATA0 packet mid-payload with an asynchronous reset.
    @(negedge clk);
    pid = 4'b0011; data = {$urandom, $urandom}; len = LW'(DB); pktready = 1'b1; pause = 1'b0;
    @(negedge clk);
    pktready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_pre_sending", sending, 1);
    #1;
    rst_L = 1'b0;
    #1;
    chk("abort_outb", outb, 0);
    chk("abort_sending", sending, 0);
    chk("abort_pktdone", pktdone, 0);
    chk("abort_gotpkt", gotpkt, 0);
    @(negedge clk);
    rst_L = 1'b1;
    run_pkt(4'b0011, '0, '0, {$urandom, $urandom}, LW'(5), 1'b0, 1'b0);
    run_pkt(4'b1001, 7'($urandom), 4'($urandom), '0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
